// File: rtl/mips_pkg.sv
// MIPS control-flow encodings and shared types for the ID-stage branch controller.
package mips_pkg;

   localparam logic [5:0] OP_SPECIAL = 6'b000000;
   localparam logic [5:0] OP_REGIMM  = 6'b000001;
   localparam logic [5:0] OP_J       = 6'b000010;
   localparam logic [5:0] OP_JAL     = 6'b000011;
   localparam logic [5:0] OP_BEQ     = 6'b000100;
   localparam logic [5:0] OP_BNE     = 6'b000101;
   localparam logic [5:0] OP_BLEZ    = 6'b000110;
   localparam logic [5:0] OP_BGTZ    = 6'b000111;

   localparam logic [5:0] FN_JR      = 6'b001000;
   localparam logic [5:0] FN_JALR    = 6'b001001;

   localparam logic [4:0] RT_BLTZ    = 5'b00000;
   localparam logic [4:0] RT_BGEZ    = 5'b00001;
   localparam logic [4:0] RT_BLTZAL  = 5'b10000;
   localparam logic [4:0] RT_BGEZAL  = 5'b10001;

   typedef enum logic [1:0] {IDLE, WAIT, REDIR} state_e;

   typedef enum logic [1:0] {CF_NONE, CF_BRANCH, CF_JUMP_ABS, CF_JUMP_REG} cf_kind_e;

   // PC-relative target: delay-slot PC plus the word-scaled, sign-extended offset.
   function automatic logic [31:0] branch_target(input logic [31:0] pc, input logic [15:0] imm);
      logic [31:0] offs;
      offs = {{14{imm[15]}}, imm, 2'b00};
      return pc + 32'd4 + offs;
   endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// ID-stage <-> branch controller signal bundle; the pipeline side is master.
interface branch_ctrl_if #(parameter int CNT_W = 16);
   logic             id_valid;
   logic [31:0]      id_instr;
   logic [31:0]      id_pc;
   logic             ops_hazard;
   logic             taken;
   logic [31:0]      jr_target;
   logic             jump;
   logic             stall_id;
   logic             redirect;
   logic [31:0]      redirect_pc;
   logic             flush_if;
   logic             link_we;
   logic             stall_timeout;
   logic [CNT_W-1:0] br_count;
   logic [CNT_W-1:0] tk_count;

   modport master (
      output id_valid, id_instr, id_pc, ops_hazard, taken, jr_target,
      input  jump, stall_id, redirect, redirect_pc, flush_if, link_we,
             stall_timeout, br_count, tk_count
   );

   modport slave (
      input  id_valid, id_instr, id_pc, ops_hazard, taken, jr_target,
      output jump, stall_id, redirect, redirect_pc, flush_if, link_we,
             stall_timeout, br_count, tk_count
   );
endinterface

// File: rtl/br_target_gen.sv
// Combinational control-flow decode, link classification and target computation.
module br_target_gen
   import mips_pkg::*;
(
   input  logic [31:0] instr_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] jr_target_i,
   output logic        cf_o,
   output logic        jump_o,
   output logic        link_o,
   output logic [31:0] target_o
);

   logic [5:0]  op;
   logic [4:0]  rt;
   logic [5:0]  funct;
   logic [31:0] pc_plus4;
   cf_kind_e    kind;

   assign op       = instr_i[31:26];
   assign rt       = instr_i[20:16];
   assign funct    = instr_i[5:0];
   assign pc_plus4 = pc_i + 32'd4;

   always_comb begin
      kind   = CF_NONE;
      link_o = 1'b0;
      case (op)
         OP_REGIMM: begin
            if (rt == RT_BLTZ || rt == RT_BGEZ) begin
               kind = CF_BRANCH;
            end else if (rt == RT_BLTZAL || rt == RT_BGEZAL) begin
               kind   = CF_BRANCH;
               link_o = 1'b1;
            end
         end
         OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: kind = CF_BRANCH;
         OP_J:   kind = CF_JUMP_ABS;
         OP_JAL: begin
            kind   = CF_JUMP_ABS;
            link_o = 1'b1;
         end
         OP_SPECIAL: begin
            if (funct == FN_JR) begin
               kind = CF_JUMP_REG;
            end else if (funct == FN_JALR) begin
               kind   = CF_JUMP_REG;
               link_o = 1'b1;
            end
         end
         default: kind = CF_NONE;
      endcase
   end

   always_comb begin
      target_o = 32'd0;
      case (kind)
         CF_BRANCH:   target_o = branch_target(pc_i, instr_i[15:0]);
         CF_JUMP_ABS: target_o = {pc_plus4[31:28], instr_i[25:0], 2'b00};
         CF_JUMP_REG: target_o = jr_target_i;
         default:     target_o = 32'd0;
      endcase
   end

   assign cf_o   = (kind != CF_NONE);
   assign jump_o = (kind == CF_JUMP_ABS) || (kind == CF_JUMP_REG);

endmodule

// File: rtl/branch_ctrl.sv
// ID-stage branch/jump sequencer: operand-wait stall, registered redirect pulse,
// and saturating resolution statistics.
module branch_ctrl
   import mips_pkg::*;
#(
   parameter int DELAY_SLOT = 1,
   parameter int MAX_STALL  = 4,
   parameter int CNT_W      = 16
) (
   input logic          clk,
   input logic          reset,
   branch_ctrl_if.slave bus
);

   localparam int            SW        = $clog2(MAX_STALL + 1);
   localparam logic [SW-1:0] STALL_MAX = SW'(MAX_STALL);

   state_e           state_q, state_d;
   logic [SW-1:0]    cnt_q, cnt_d;
   logic             redirect_q, redirect_d;
   logic [31:0]      rpc_q, rpc_d;
   logic             flush_q, flush_d;
   logic             link_q, link_d;
   logic             tmo_q, tmo_d;
   logic [CNT_W-1:0] br_q, br_d;
   logic [CNT_W-1:0] tk_q, tk_d;

   logic        cf, is_jump, is_link, eff_taken;
   logic        resolve, stall;
   logic [31:0] target;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   br_target_gen u_tgt (
      .instr_i     (bus.id_instr),
      .pc_i        (bus.id_pc),
      .jr_target_i (bus.jr_target),
      .cf_o        (cf),
      .jump_o      (is_jump),
      .link_o      (is_link),
      .target_o    (target)
   );

   // Unconditional jumps are taken regardless of what the compare unit reports.
   assign eff_taken = bus.taken | is_jump;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      redirect_d = 1'b0;
      rpc_d      = 32'd0;
      flush_d    = 1'b0;
      link_d     = 1'b0;
      tmo_d      = tmo_q;
      br_d       = br_q;
      tk_d       = tk_q;
      resolve    = 1'b0;
      stall      = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.id_valid && cf) begin
               if (bus.ops_hazard) begin
                  stall   = 1'b1;
                  cnt_d   = SW'(1);
                  state_d = WAIT;
               end else begin
                  resolve = 1'b1;
                  state_d = REDIR;
               end
            end
         end
         WAIT: begin
            if (!bus.id_valid) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else if (!bus.ops_hazard) begin
               resolve = 1'b1;
               cnt_d   = '0;
               state_d = REDIR;
            end else begin
               stall = 1'b1;
               if (cnt_q != STALL_MAX) cnt_d = cnt_q + SW'(1);
            end
         end
         // The delay-slot instruction sits in ID here and is deliberately ignored.
         REDIR:   state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (stall && cnt_d == STALL_MAX) tmo_d = 1'b1;

      if (resolve) begin
         br_d = sat_inc(br_q);
         if (eff_taken) begin
            tk_d       = sat_inc(tk_q);
            redirect_d = 1'b1;
            rpc_d      = target;
            flush_d    = (DELAY_SLOT == 0);
            link_d     = is_link;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         redirect_q <= 1'b0;
         rpc_q      <= 32'd0;
         flush_q    <= 1'b0;
         link_q     <= 1'b0;
         tmo_q      <= 1'b0;
         br_q       <= '0;
         tk_q       <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         redirect_q <= redirect_d;
         rpc_q      <= rpc_d;
         flush_q    <= flush_d;
         link_q     <= link_d;
         tmo_q      <= tmo_d;
         br_q       <= br_d;
         tk_q       <= tk_d;
      end
   end

   assign bus.jump          = is_jump;
   assign bus.stall_id      = stall;
   assign bus.redirect      = redirect_q;
   assign bus.redirect_pc   = rpc_q;
   assign bus.flush_if      = flush_q;
   assign bus.link_we       = link_q;
   assign bus.stall_timeout = tmo_q;
   assign bus.br_count      = br_q;
   assign bus.tk_count      = tk_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: delay-slot instance A and flush/narrow-counter instance B.
module tb_branch_ctrl;

   localparam logic [31:0] I_NOP    = 32'h0000_0000;
   localparam logic [31:0] I_BEQ    = 32'h1022_0004;
   localparam logic [31:0] I_BNE    = 32'h1422_FFFE;
   localparam logic [31:0] I_BGEZAL = 32'h0431_0008;
   localparam logic [31:0] I_JR     = 32'h03E0_0008;
   localparam logic [31:0] I_JALR   = 32'h0080_F809;
   localparam logic [31:0] I_JAL    = 32'h0C10_0000;

   logic clk = 1'b0;
   logic reset;
   int   vectors = 0;
   int   errs = 0;

   always #5 clk = ~clk;

   branch_ctrl_if #(.CNT_W(16)) ifa ();
   branch_ctrl_if #(.CNT_W(2))  ifb ();

   branch_ctrl #(.DELAY_SLOT(1), .MAX_STALL(4), .CNT_W(16)) dut_a (
      .clk(clk), .reset(reset), .bus(ifa)
   );
   branch_ctrl #(.DELAY_SLOT(0), .MAX_STALL(4), .CNT_W(2)) dut_b (
      .clk(clk), .reset(reset), .bus(ifb)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_a(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic hz, input logic tk, input logic [31:0] jr);
      ifa.id_valid = v; ifa.id_instr = ins; ifa.id_pc = pc;
      ifa.ops_hazard = hz; ifa.taken = tk; ifa.jr_target = jr;
   endtask

   task automatic set_b(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic hz, input logic tk, input logic [31:0] jr);
      ifb.id_valid = v; ifb.id_instr = ins; ifb.id_pc = pc;
      ifb.ops_hazard = hz; ifb.taken = tk; ifb.jr_target = jr;
   endtask

   initial begin
      reset = 1'b1;
      set_a(0, I_NOP, 0, 0, 0, 0);
      set_b(0, I_NOP, 0, 0, 0, 0);
      step(); step();
      chk("rst_redirect", ifa.redirect, 0);
      chk("rst_rpc", ifa.redirect_pc, 0);
      chk("rst_br", ifa.br_count, 0);
      chk("rst_tk", ifa.tk_count, 0);
      chk("rst_tmo", ifa.stall_timeout, 0);
      reset = 1'b0;
      step();

      // BEQ taken, no hazard
      set_a(1, I_BEQ, 32'h0040_0010, 0, 1, 0);
      #1 chk("beq_stall", ifa.stall_id, 0);
      chk("beq_jump", ifa.jump, 0);
      step();
      chk("beq_redirect", ifa.redirect, 1);
      chk("beq_rpc", ifa.redirect_pc, 32'h0040_0024);
      chk("beq_flush", ifa.flush_if, 0);
      chk("beq_link", ifa.link_we, 0);
      chk("beq_br", ifa.br_count, 1);
      chk("beq_tk", ifa.tk_count, 1);
      set_a(0, I_NOP, 0, 0, 0, 0);
      step();
      chk("beq_pulse_end", ifa.redirect, 0);

      // BNE not taken, then BEQ in the delay slot is ignored
      set_a(1, I_BNE, 32'h0040_0100, 0, 0, 0);
      step();
      chk("bne_redirect", ifa.redirect, 0);
      chk("bne_br", ifa.br_count, 2);
      chk("bne_tk", ifa.tk_count, 1);
      set_a(1, I_BEQ, 32'h0040_0104, 0, 1, 0);
      step();
      chk("slot_redirect", ifa.redirect, 0);
      chk("slot_br", ifa.br_count, 2);
      chk("slot_tk", ifa.tk_count, 1);
      set_a(0, I_NOP, 0, 0, 0, 0);
      step();

      // BGEZAL with two hazard cycles
      set_a(1, I_BGEZAL, 32'h0040_0200, 1, 0, 0);
      #1 chk("bgezal_stall0", ifa.stall_id, 1);
      step();
      chk("bgezal_stall1", ifa.stall_id, 1);
      step();
      set_a(1, I_BGEZAL, 32'h0040_0200, 0, 1, 0);
      #1 chk("bgezal_stall2", ifa.stall_id, 0);
      chk("bgezal_noredir_yet", ifa.redirect, 0);
      step();
      chk("bgezal_redirect", ifa.redirect, 1);
      chk("bgezal_rpc", ifa.redirect_pc, 32'h0040_0224);
      chk("bgezal_link", ifa.link_we, 1);
      chk("bgezal_tmo", ifa.stall_timeout, 0);
      chk("bgezal_br", ifa.br_count, 3);
      chk("bgezal_tk", ifa.tk_count, 2);
      set_a(0, I_NOP, 0, 0, 0, 0);
      step();
      chk("bgezal_pulse_end", ifa.redirect, 0);
      chk("bgezal_link_end", ifa.link_we, 0);

      // Hazard held six cycles: timeout appears after the fourth stall cycle
      set_a(1, I_BEQ, 32'h0040_0300, 1, 0, 0);
      step(); step(); step();
      chk("tmo_after3", ifa.stall_timeout, 0);
      step();
      chk("tmo_after4", ifa.stall_timeout, 1);
      step(); step();
      chk("tmo_still_stall", ifa.stall_id, 1);
      set_a(1, I_BEQ, 32'h0040_0300, 0, 0, 0);
      step();
      chk("tmo_redirect", ifa.redirect, 0);
      chk("tmo_br", ifa.br_count, 4);
      chk("tmo_tk", ifa.tk_count, 2);
      set_a(0, I_NOP, 0, 0, 0, 0);
      step();
      chk("tmo_sticky", ifa.stall_timeout, 1);

      // JR and JAL
      set_a(1, I_JR, 32'h0040_0400, 0, 1, 32'h8000_0180);
      #1 chk("jr_jump", ifa.jump, 1);
      step();
      chk("jr_redirect", ifa.redirect, 1);
      chk("jr_rpc", ifa.redirect_pc, 32'h8000_0180);
      chk("jr_link", ifa.link_we, 0);
      set_a(0, I_NOP, 0, 0, 0, 0);
      step();
      set_a(1, I_JAL, 32'h0040_0000, 0, 1, 0);
      step();
      chk("jal_rpc", ifa.redirect_pc, 32'h0040_0000);
      chk("jal_link", ifa.link_we, 1);
      chk("jal_flush", ifa.flush_if, 0);
      chk("jal_br", ifa.br_count, 6);
      chk("jal_tk", ifa.tk_count, 4);
      set_a(0, I_NOP, 0, 0, 0, 0);
      step();

      // Upstream flush while waiting abandons the branch
      set_a(1, I_BEQ, 32'h0040_0500, 1, 1, 0);
      step();
      set_a(0, I_NOP, 0, 0, 0, 0);
      step();
      chk("abandon_redirect", ifa.redirect, 0);
      chk("abandon_br", ifa.br_count, 6);
      set_a(1, I_BEQ, 32'h0040_0010, 0, 1, 0);
      #1 chk("abandon_idle", ifa.stall_id, 0);
      step();
      chk("abandon_next_rpc", ifa.redirect_pc, 32'h0040_0024);
      set_a(0, I_NOP, 0, 0, 0, 0);
      step();

      // Instance B: JALR with IF flush, then counter saturation at 2 bits
      set_b(1, I_JALR, 32'h0040_0500, 0, 1, 32'h0040_1000);
      step();
      chk("jalr_redirect", ifb.redirect, 1);
      chk("jalr_flush", ifb.flush_if, 1);
      chk("jalr_link", ifb.link_we, 1);
      chk("jalr_rpc", ifb.redirect_pc, 32'h0040_1000);
      set_b(0, I_NOP, 0, 0, 0, 0);
      step();
      for (int i = 0; i < 3; i++) begin
         set_b(1, I_BEQ, 32'h0040_0010, 0, 1, 0);
         step();
         if (i == 1) chk("sat_pre_tk", ifb.tk_count, 3);
         set_b(0, I_NOP, 0, 0, 0, 0);
         step();
      end
      chk("sat_tk", ifb.tk_count, 3);
      chk("sat_br", ifb.br_count, 3);

      // Reset mid-WAIT (B) and mid-REDIR (A)
      set_b(1, I_BEQ, 32'h0040_0600, 1, 1, 0);
      step(); step();
      set_a(1, I_JAL, 32'h0040_0000, 0, 1, 0);
      step();
      chk("pre_rst_redirect", ifa.redirect, 1);
      reset = 1'b1;
      #1;
      chk("arst_redirect", ifa.redirect, 0);
      chk("arst_rpc", ifa.redirect_pc, 0);
      chk("arst_link", ifa.link_we, 0);
      chk("arst_tmo", ifa.stall_timeout, 0);
      chk("arst_br_a", ifa.br_count, 0);
      chk("arst_tk_b", ifb.tk_count, 0);
      chk("arst_br_b", ifb.br_count, 0);
      set_a(0, I_NOP, 0, 0, 0, 0);
      set_b(0, I_NOP, 0, 0, 0, 0);
      step();
      reset = 1'b0;
      step();
      chk("post_rst_redirect_a", ifa.redirect, 0);
      chk("post_rst_redirect_b", ifb.redirect, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- Sequences branch/jump resolution in the ID stage of the 5-stage MIPS pipeline around the quick-compare unit.
- Detects branch/jump opcodes and stalls IF/ID while compare operands are not yet forwardable.
- Samples the compare unit's taken result, computes the target, and issues a registered one-cycle PC redirect plus an IF flush.
- Keeps saturating branch/taken statistics counters.

Parameters:
- DELAY_SLOT, 1, 1 = MIPS delay slot honoured (no IF flush on redirect); 0 = flush the IF instruction on redirect.
- MAX_STALL, 4, operand-wait cycles before the timeout flag is raised.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID stage holds a valid instruction.
- id_instr  in  32  ID-stage instruction (the same word the compare unit sees).
- id_pc  in  32  PC of the ID instruction.
- ops_hazard  in  1  rs/rt of the ID instruction depend on a not-yet-forwardable producer (load in EX/MEM).
- taken  in  1  from the compare unit (branch condition OR jump).
- jr_target  in  32  forwarded rs value for JR/JALR.
- jump  out  1  combinational decode of J/JAL/JR/JALR, fed to the compare unit.
- stall_id  out  1  hold PC and IF/ID.
- redirect  out  1  registered one-cycle PC-load pulse.
- redirect_pc  out  32  registered target, valid while redirect=1.
- flush_if  out  1  registered; equals redirect when DELAY_SLOT=0, else 0.
- link_we  out  1  registered; a taken-or-jump AL-class instruction must write $31 (BLTZAL, BGEZAL, JAL) or rd (JALR).
- stall_timeout  out  1  sticky flag; cleared only by reset.
- br_count  out  CNT_W  saturating count of resolved branches/jumps.
- tk_count  out  CNT_W  saturating count of resolved taken branches/jumps.

Behaviour:
- Reset: state IDLE; every registered output is 0 (redirect, redirect_pc, flush_if, link_we, stall_timeout, br_count, tk_count); the stall counter is 0.
- Control-flow decode covers:
  - opcode 000001 with rt 00000/00001/10000/10001;
  - opcodes 000100–000111;
  - J 000010 and JAL 000011;
  - opcode 000000 with funct 001000 (JR) or 001001 (JALR).
- States and transitions:
  - IDLE: on id_valid & cf & ops_hazard, assert stall_id, load stall counter = 1, go to WAIT. On id_valid & cf & !ops_hazard, resolve this cycle and go to REDIR.
  - WAIT: stall_id = 1 and the counter increments each cycle. When ops_hazard drops, resolve that cycle (stall_id = 0) and go to REDIR. When the counter reaches MAX_STALL with the hazard still high, set stall_timeout and keep waiting. The counter saturates at MAX_STALL.
  - REDIR: one cycle. The registered redirect/flush_if/link_we reflect the resolution. A cf instruction in ID during this cycle (the delay slot) is not resolved: no redirect, not counted. Then return to IDLE.
- Resolve actions:
  - Increment br_count.
  - If taken, increment tk_count and set redirect = 1 with redirect_pc as follows:
    - conditional branch: id_pc + 4 + (sign-extended imm16 << 2), modulo 2^32;
    - J/JAL: {id_pc+4 [31:28], instr[25:0], 2'b00};
    - JR/JALR: jr_target.
  - link_we = 1 for AL-class instructions when resolved as taken. JAL/JALR always count as taken; BLTZAL/BGEZAL write the link only when taken.
- Not taken: no redirect; the state still passes through REDIR, which keeps the delay-slot rule uniform.
- Counters saturate at all-ones and do not wrap.
- id_valid = 0 while in WAIT: abandon the wait, return to IDLE, and resolve nothing (upstream flush).
- Asynchronous reset mid-WAIT or mid-REDIR: immediate return to the reset values; no redirect pulse leaks.

Decomposition:
- Shared package mips_pkg: opcode/funct/rt constants (OP_REGIMM, OP_BEQ…OP_BGTZ, OP_J, OP_JAL, FN_JR, FN_JALR, RT_BLTZ…RT_BGEZAL), state enum {IDLE, WAIT, REDIR}.
- One natural sub-module, br_target_gen: a purely combinational target/link-class computation, kept separately testable.
- The FSM, counters and output registers stay in branch_ctrl.

Test Plan:
- BEQ at id_pc=0x00400010, imm=0x0004, taken=1, no hazard → next cycle redirect=1, redirect_pc=0x00400024, flush_if=0 (DELAY_SLOT=1), br_count=1, tk_count=1.
- BNE at 0x00400100, imm=0xFFFE, taken=0 → no redirect; br_count=1, tk_count=0; a BEQ in the following (delay-slot) cycle is ignored.
- BGEZAL with ops_hazard high for 2 cycles, then taken=1 → stall_id high for exactly 2 cycles, then redirect and link_we pulse for one cycle; stall_timeout=0.
- ops_hazard held for 6 cycles with MAX_STALL=4 → stall_timeout set in the 4th stall cycle and still set after resolution.
- JR with jr_target=0x8000_0180 → redirect_pc=0x80000180. JAL at 0x0040_0000 with instr[25:0]=0x0100000 → redirect_pc=0x00400000, link_we=1. With DELAY_SLOT=0, flush_if=1.
- Reset asserted during WAIT; tk_count preloaded near saturation (0xFFFF), then one more taken branch → all outputs 0 immediately on reset; in the saturation case tk_count stays 0xFFFF.
